trisc_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer for the TRISC accumulator processor.
- Consumes the one-hot instruction decode vector (11 bits), the accumulator Z/N flags and the memory ready handshake.
- Steps through fetch, decode and execute, and emits the per-cycle datapath strobes: PC, MAR, IR, ACC, ALU op and memory read/write.
- Sits between the instruction decoder and the datapath/memory.

---
 rtl/trisc_ctrl_seq_if.sv | 34 +++
 rtl/trisc_ctrl_seq.sv | 135 +++++++++++++
 tb/tb_trisc_ctrl_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/trisc_ctrl_seq_if.sv
// Bundle between the TRISC control sequencer and its decoder/datapath/memory neighbours.
// Memory handshake: mem_rd/mem_wr is a request held until the cycle mem_rdy=1, which completes the transfer.
interface trisc_ctrl_seq_if #(parameter int CNT_W = 16);
  logic             run;
  logic [10:0]      id;
  logic             z;
  logic             n;
  logic             mem_rdy;
  logic             mar_ld;
  logic             addr_sel;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_ld;
  logic             pc_inc;
  logic             pc_ld;
  logic             acc_ld;
  logic [2:0]       alu_op;
  logic             illegal;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, id, z, n, mem_rdy,
    input  mar_ld, addr_sel, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, acc_ld,
    input  alu_op, illegal, halted, state, instr_cnt
  );

  modport slave (
    input  run, id, z, n, mem_rdy,
    output mar_ld, addr_sel, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, acc_ld,
    output alu_op, illegal, halted, state, instr_cnt
  );
endinterface

// File: rtl/trisc_ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the TRISC accumulator machine.
// Emits per-cycle datapath strobes and counts retired instructions.
module trisc_ctrl_seq #(
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    trisc_ctrl_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_F1   = 3'd1,
        S_D    = 3'd2,
        S_E    = 3'd3,
        S_HALT = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             id_onehot;
    logic             mar_ld, addr_sel, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, acc_ld, illegal;
    logic [2:0]       alu_op;

    assign id_onehot = (bus.id != 11'd0) && ((bus.id & (bus.id - 11'd1)) == 11'd0);

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        mar_ld   = 1'b0;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        acc_ld   = 1'b0;
        alu_op   = 3'b000;
        illegal  = 1'b0;
        case (state_q)
            S_F0: begin
                if (bus.run) begin
                    mar_ld  = 1'b1;
                    state_d = S_F1;
                end
            end
            S_F1: begin
                mem_rd = 1'b1;
                if (bus.mem_rdy) begin
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_D;
                end
            end
            S_D: begin
                state_d = S_F0;
                if (!id_onehot) begin
                    illegal = 1'b1;
                end else if (bus.id[4:0] != 5'd0) begin
                    mar_ld   = 1'b1;
                    addr_sel = 1'b1;
                    state_d  = S_E;
                end else begin
                    // Everything else completes in decode; only the strobes differ.
                    retire = 1'b1;
                    if (bus.id[5]) begin
                        acc_ld = 1'b1;
                        alu_op = 3'b100;
                    end else if (bus.id[6]) begin
                        acc_ld = 1'b1;
                        alu_op = 3'b101;
                    end else if (bus.id[7]) begin
                        pc_ld = 1'b1;
                    end else if (bus.id[8]) begin
                        pc_ld = bus.z;
                    end else if (bus.id[9]) begin
                        pc_ld = bus.n;
                    end else begin
                        state_d = S_HALT;
                    end
                end
            end
            S_E: begin
                mem_wr = bus.id[1];
                mem_rd = !bus.id[1];
                if (bus.mem_rdy) begin
                    retire  = 1'b1;
                    state_d = S_F0;
                    acc_ld  = !bus.id[1];
                    if (bus.id[2])      alu_op = 3'b001;
                    else if (bus.id[3]) alu_op = 3'b010;
                    else if (bus.id[4]) alu_op = 3'b011;
                    else                alu_op = 3'b000;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_F0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_F0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == S_HALT);
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Strobes are squashed while reset is held so an in-flight write cannot complete.
    assign bus.mar_ld    = rst_n & mar_ld;
    assign bus.addr_sel  = rst_n & addr_sel;
    assign bus.mem_rd    = rst_n & mem_rd;
    assign bus.mem_wr    = rst_n & mem_wr;
    assign bus.ir_ld     = rst_n & ir_ld;
    assign bus.pc_inc    = rst_n & pc_inc;
    assign bus.pc_ld     = rst_n & pc_ld;
    assign bus.acc_ld    = rst_n & acc_ld;
    assign bus.alu_op    = (rst_n && acc_ld) ? alu_op : 3'b000;
    assign bus.illegal   = rst_n & illegal;
    assign bus.halted    = halted_q;
    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_trisc_ctrl_seq.sv
// Bench for trisc_ctrl_seq: instruction-level trace generator feeding stimulus and expected queues.
module tb_trisc_ctrl_seq;
  localparam int CNT_W = 4;
  localparam int EXP_W = CNT_W + 16;
  localparam int STIM_W = 15;

  logic clk;
  logic rst_n;

  trisc_ctrl_seq_if #(.CNT_W(CNT_W)) bus ();

  trisc_ctrl_seq #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0]  m_cnt;
  logic [STIM_W-1:0] stim_q[$];
  logic [EXP_W-1:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [11:0] strb(input logic mar, input logic adr, input logic rd,
                                       input logic wr, input logic ir, input logic pinc,
                                       input logic pld, input logic acc, input logic [2:0] alu,
                                       input logic ill);
    return {mar, adr, rd, wr, ir, pinc, pld, acc, alu, ill};
  endfunction

  function automatic logic [11:0] obs_strb();
    return {bus.mar_ld, bus.addr_sel, bus.mem_rd, bus.mem_wr, bus.ir_ld, bus.pc_inc,
            bus.pc_ld, bus.acc_ld, bus.alu_op, bus.illegal};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // one clock cycle of stimulus plus what the outputs must be during it
  task automatic push(input logic r, input logic [10:0] idv, input logic zv, input logic nv,
                      input logic rdy, input logic [2:0] st, input logic h, input logic [11:0] s);
    stim_q.push_back({r, idv, zv, nv, rdy});
    exp_q.push_back({st, h, m_cnt, s});
  endtask

  // Expands one instruction into its cycle trace from the architectural rules.
  task automatic plan_instr(input logic [10:0] idv, input int w0, input int w1, input int w2,
                            input logic zv, input logic nv, input logic abort);
    logic [2:0]  alu;
    logic        sta;
    logic [11:0] s;
    for (int i = 0; i < w0; i++)
      push(1'b0, 11'($urandom), rbit(), rbit(), rbit(), 3'd0, 1'b0, 12'd0);
    push(1'b1, 11'($urandom), rbit(), rbit(), rbit(), 3'd0, 1'b0,
         strb(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
    for (int i = 0; i < w1; i++)
      push(rbit(), 11'($urandom), rbit(), rbit(), 1'b0, 3'd1, 1'b0,
           strb(0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0));
    push(rbit(), 11'($urandom), rbit(), rbit(), 1'b1, 3'd1, 1'b0,
         strb(0, 0, 1, 0, 1, 1, 0, 0, 3'd0, 0));
    if ($countones(idv) != 1) begin
      push(rbit(), idv, zv, nv, rbit(), 3'd2, 1'b0, strb(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1));
    end else if (idv[4:0] != 5'd0) begin
      push(rbit(), idv, zv, nv, rbit(), 3'd2, 1'b0, strb(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0));
      sta = idv[1];
      alu = idv[2] ? 3'd1 : idv[3] ? 3'd2 : idv[4] ? 3'd3 : 3'd0;
      for (int i = 0; i < w2; i++)
        push(rbit(), idv, rbit(), rbit(), 1'b0, 3'd3, 1'b0,
             strb(0, 0, !sta, sta, 0, 0, 0, 0, 3'd0, 0));
      if (abort) return;
      push(rbit(), idv, rbit(), rbit(), 1'b1, 3'd3, 1'b0,
           strb(0, 0, !sta, sta, 0, 0, 0, !sta, sta ? 3'd0 : alu, 0));
      m_cnt = m_cnt + 1'b1;
    end else begin
      if (idv[5])      s = strb(0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 0);
      else if (idv[6]) s = strb(0, 0, 0, 0, 0, 0, 0, 1, 3'd5, 0);
      else if (idv[7]) s = strb(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 0);
      else if (idv[8]) s = strb(0, 0, 0, 0, 0, 0, zv, 0, 3'd0, 0);
      else if (idv[9]) s = strb(0, 0, 0, 0, 0, 0, nv, 0, 3'd0, 0);
      else             s = 12'd0;
      push(rbit(), idv, zv, nv, rbit(), 3'd2, 1'b0, s);
      m_cnt = m_cnt + 1'b1;
      if (idv[10])
        for (int i = 0; i < 20; i++)
          push(rbit(), 11'($urandom), rbit(), rbit(), rbit(), 3'd5, 1'b1, 12'd0);
    end
  endtask

  // driver + scoreboard: one queued entry per clock, sampled 1 ns after the falling edge
  task automatic drain();
    logic [STIM_W-1:0] s;
    logic [EXP_W-1:0]  e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      bus.run     = s[14];
      bus.id      = s[13:3];
      bus.z       = s[2];
      bus.n       = s[1];
      bus.mem_rdy = s[0];
      #1;
      check_eq("state", 32'(bus.state), 32'(e[EXP_W-1 -: 3]));
      check_eq("halted", 32'(bus.halted), 32'(e[CNT_W+12]));
      check_eq("instr_cnt", 32'(bus.instr_cnt), 32'(e[CNT_W+11 -: CNT_W]));
      check_eq("strobes", 32'(obs_strb()), 32'(e[11:0]));
    end
  endtask

  // asynchronous reset asserted mid-cycle, checked before the next rising edge
  task automatic reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_state"}, 32'(bus.state), 32'd0);
    check_eq({tag, "_halted"}, 32'(bus.halted), 32'd0);
    check_eq({tag, "_cnt"}, 32'(bus.instr_cnt), 32'd0);
    check_eq({tag, "_strobes"}, 32'(obs_strb()), 32'd0);
    @(negedge clk);
    bus.run = 1'b1;
    bus.id = 11'h001;
    bus.mem_rdy = 1'b1;
    #1;
    check_eq({tag, "_held_strobes"}, 32'(obs_strb()), 32'd0);
    bus.run = 1'b0;
    rst_n = 1'b1;
    m_cnt = '0;
  endtask

  initial begin
    logic [10:0] idv;
    int k;
    m_cnt = '0;
    bus.run = 1'b1;
    bus.id = 11'h001;
    bus.z = 1'b0;
    bus.n = 1'b0;
    bus.mem_rdy = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_state", 32'(bus.state), 32'd0);
    check_eq("rst_halted", 32'(bus.halted), 32'd0);
    check_eq("rst_cnt", 32'(bus.instr_cnt), 32'd0);
    check_eq("rst_strobes", 32'(obs_strb()), 32'd0);
    @(negedge clk);
    #1;
    check_eq("rst_held_strobes", 32'(obs_strb()), 32'd0);
    bus.run = 1'b0;
    rst_n = 1'b1;

    // directed: LDA, stalled STA, conditional jumps, illegal decodes
    plan_instr(11'h001, 0, 0, 0, 1'b0, 1'b0, 1'b0); drain();
    plan_instr(11'h002, 1, 2, 3, 1'b0, 1'b0, 1'b0); drain();
    plan_instr(11'h100, 0, 0, 0, 1'b0, 1'b0, 1'b0); drain();
    plan_instr(11'h100, 0, 0, 0, 1'b1, 1'b0, 1'b0); drain();
    plan_instr(11'h200, 0, 0, 0, 1'b0, 1'b0, 1'b0); drain();
    plan_instr(11'h200, 0, 0, 0, 1'b0, 1'b1, 1'b0); drain();
    plan_instr(11'h000, 0, 0, 0, 1'b0, 1'b0, 1'b0); drain();
    plan_instr(11'h003, 0, 0, 0, 1'b0, 1'b0, 1'b0); drain();
    // counter wraps through 15 -> 0
    for (int i = 0; i < 16; i++) plan_instr(11'h020, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    drain();
    plan_instr(11'h040, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    plan_instr(11'h004, 0, 1, 2, 1'b0, 1'b0, 1'b0);
    plan_instr(11'h008, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    plan_instr(11'h010, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    plan_instr(11'h080, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    drain();
    plan_instr(11'h400, 0, 0, 0, 1'b0, 1'b0, 1'b0); drain();
    reset_mid("halt_rst");
    // reset while a store waits for memory
    plan_instr(11'h002, 0, 0, 2, 1'b0, 1'b0, 1'b1); drain();
    reset_mid("sta_abort");

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(11, 0);
      if (k <= 10) begin
        idv = 11'd1 << k;
      end else begin
        idv = 11'($urandom);
        if ($countones(idv) == 1) idv = 11'h000;
      end
      plan_instr(idv, $urandom_range(2, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                 rbit(), rbit(), 1'b0);
      drain();
      if (k == 10) reset_mid("rand_halt");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
